// File: rtl/br_update_pkg.sv
// Shared types and constants for the branch update unit.
// Port fields whose widths track module parameters travel beside brinfo_t.
package br_update_pkg;

    localparam int NUM_BRINFO_DEF = 3;
    localparam int MAX_BR_DEF     = 20;
    localparam int BR_TAG_W_DEF   = 5;
    localparam int ROB_IDX_W_DEF  = 7;

    localparam logic [2:0] CFI_BR   = 3'd1;
    localparam logic [2:0] CFI_JALR = 3'd3;

    localparam logic [1:0] PC_SEL_PLUS4 = 2'd0;
    localparam logic [1:0] PC_SEL_BRJMP = 2'd1;
    localparam logic [1:0] PC_SEL_JALR  = 2'd2;

    typedef struct packed {
        logic        mispredict;
        logic        taken;
        logic [2:0]  cfi_type;
        logic [1:0]  pc_sel;
        logic [20:0] target_offset;
        logic [5:0]  ftq_idx;
        logic [5:0]  pc_lob;
        logic [4:0]  ldq_idx;
        logic [4:0]  stq_idx;
        logic        is_rvc;
        logic        edge_inst;
    } brinfo_t;

endpackage

// File: rtl/br_oldest_select.sv
// One-hot grant to the oldest requester, age measured from the ROB head.
// Equal ages go to the lowest port index.
module br_oldest_select #(
    parameter int N     = 3,
    parameter int IDX_W = 7
) (
    input  logic [N-1:0]            req,
    input  logic [N-1:0][IDX_W-1:0] rob_idx,
    input  logic [IDX_W-1:0]        head_idx,
    output logic [N-1:0]            gnt
);

    logic [IDX_W-1:0] key;
    logic [IDX_W-1:0] best_key;
    logic             found;

    always_comb begin
        gnt      = '0;
        key      = '0;
        best_key = '0;
        found    = 1'b0;
        for (int i = 0; i < N; i++) begin
            // Modular distance from head; strict < keeps the lower port on ties.
            key = rob_idx[i] - head_idx;
            if (req[i] && (!found || key < best_key)) begin
                gnt      = '0;
                gnt[i]   = 1'b1;
                best_key = key;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/br_update_unit.sv
// Merges per-unit branch resolutions into the core-wide update:
// b1 masks one cycle after the reports, oldest-branch details (b2) one cycle later.
module br_update_unit
    import br_update_pkg::*;
#(
    parameter int NUM_BRINFO = NUM_BRINFO_DEF,
    parameter int MAX_BR     = MAX_BR_DEF,
    parameter int BR_TAG_W   = BR_TAG_W_DEF,
    parameter int ROB_IDX_W  = ROB_IDX_W_DEF
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  flush,
    input  logic [ROB_IDX_W-1:0]                  rob_head_idx,
    input  logic [NUM_BRINFO-1:0]                 brinfo_valid,
    input  logic [NUM_BRINFO-1:0]                 brinfo_mispredict,
    input  logic [NUM_BRINFO-1:0]                 brinfo_taken,
    input  logic [NUM_BRINFO-1:0][2:0]            brinfo_cfi_type,
    input  logic [NUM_BRINFO-1:0][1:0]            brinfo_pc_sel,
    input  logic [NUM_BRINFO-1:0][20:0]           brinfo_target_offset,
    input  logic [NUM_BRINFO-1:0][MAX_BR-1:0]     brinfo_br_mask,
    input  logic [NUM_BRINFO-1:0][BR_TAG_W-1:0]   brinfo_br_tag,
    input  logic [NUM_BRINFO-1:0][ROB_IDX_W-1:0]  brinfo_rob_idx,
    input  logic [NUM_BRINFO-1:0][5:0]            brinfo_ftq_idx,
    input  logic [NUM_BRINFO-1:0][5:0]            brinfo_pc_lob,
    input  logic [NUM_BRINFO-1:0][4:0]            brinfo_ldq_idx,
    input  logic [NUM_BRINFO-1:0][4:0]            brinfo_stq_idx,
    input  logic [NUM_BRINFO-1:0]                 brinfo_is_rvc,
    input  logic [NUM_BRINFO-1:0]                 brinfo_edge_inst,
    output logic [MAX_BR-1:0]                     b1_resolve_mask,
    output logic [MAX_BR-1:0]                     b1_mispredict_mask,
    output logic                                  b2_valid,
    output logic                                  b2_mispredict,
    output logic                                  b2_taken,
    output logic [2:0]                            b2_cfi_type,
    output logic [1:0]                            b2_pc_sel,
    output logic [20:0]                           b2_target_offset,
    output logic [MAX_BR-1:0]                     b2_br_mask,
    output logic [BR_TAG_W-1:0]                   b2_br_tag,
    output logic [ROB_IDX_W-1:0]                  b2_rob_idx,
    output logic [5:0]                            b2_ftq_idx,
    output logic [5:0]                            b2_pc_lob,
    output logic [4:0]                            b2_ldq_idx,
    output logic [4:0]                            b2_stq_idx,
    output logic                                  b2_is_rvc,
    output logic                                  b2_edge_inst
);

    localparam logic [MAX_BR-1:0] TAG_ONE = MAX_BR'(1);

    brinfo_t [NUM_BRINFO-1:0] port_info;
    logic    [NUM_BRINFO-1:0] live, mp_req, mp_gnt, live_gnt, win_gnt;

    logic [MAX_BR-1:0]    b1_resolve_mask_d, b1_resolve_mask_q;
    logic [MAX_BR-1:0]    b1_mispredict_mask_d, b1_mispredict_mask_q;
    logic                 s1_valid_d, s1_valid_q;
    brinfo_t              s1_info_d, s1_info_q;
    logic [MAX_BR-1:0]    s1_br_mask_d, s1_br_mask_q;
    logic [BR_TAG_W-1:0]  s1_br_tag_d, s1_br_tag_q;
    logic [ROB_IDX_W-1:0] s1_rob_idx_d, s1_rob_idx_q;
    logic                 b2_valid_d, b2_valid_q;
    brinfo_t              b2_info_d, b2_info_q;
    logic [MAX_BR-1:0]    b2_br_mask_d, b2_br_mask_q;
    logic [BR_TAG_W-1:0]  b2_br_tag_d, b2_br_tag_q;
    logic [ROB_IDX_W-1:0] b2_rob_idx_d, b2_rob_idx_q;

    for (genvar g = 0; g < NUM_BRINFO; g++) begin : g_port
        assign port_info[g] = '{
            mispredict:    brinfo_mispredict[g],
            taken:         brinfo_taken[g],
            cfi_type:      brinfo_cfi_type[g],
            pc_sel:        brinfo_pc_sel[g],
            target_offset: brinfo_target_offset[g],
            ftq_idx:       brinfo_ftq_idx[g],
            pc_lob:        brinfo_pc_lob[g],
            ldq_idx:       brinfo_ldq_idx[g],
            stq_idx:       brinfo_stq_idx[g],
            is_rvc:        brinfo_is_rvc[g],
            edge_inst:     brinfo_edge_inst[g]
        };
        // A report under the mispredict already on b1 is on the wrong path.
        assign live[g]   = brinfo_valid[g] & ~flush
                         & ~|(brinfo_br_mask[g] & b1_mispredict_mask_q);
        assign mp_req[g] = live[g] & brinfo_mispredict[g];
    end

    br_oldest_select #(.N(NUM_BRINFO), .IDX_W(ROB_IDX_W)) u_sel_mp (
        .req      (mp_req),
        .rob_idx  (brinfo_rob_idx),
        .head_idx (rob_head_idx),
        .gnt      (mp_gnt)
    );

    br_oldest_select #(.N(NUM_BRINFO), .IDX_W(ROB_IDX_W)) u_sel_live (
        .req      (live),
        .rob_idx  (brinfo_rob_idx),
        .head_idx (rob_head_idx),
        .gnt      (live_gnt)
    );

    assign win_gnt = (|mp_gnt) ? mp_gnt : live_gnt;

    always_comb begin
        b1_resolve_mask_d    = '0;
        b1_mispredict_mask_d = '0;
        s1_info_d            = '0;
        s1_br_mask_d         = '0;
        s1_br_tag_d          = '0;
        s1_rob_idx_d         = '0;
        for (int i = 0; i < NUM_BRINFO; i++) begin
            // Shifting within MAX_BR bits drops tags at or above MAX_BR.
            if (live[i])
                b1_resolve_mask_d = b1_resolve_mask_d | (TAG_ONE << brinfo_br_tag[i]);
            if (mp_gnt[i])
                b1_mispredict_mask_d = TAG_ONE << brinfo_br_tag[i];
            if (win_gnt[i]) begin
                s1_info_d    = port_info[i];
                s1_br_mask_d = brinfo_br_mask[i];
                s1_br_tag_d  = brinfo_br_tag[i];
                s1_rob_idx_d = brinfo_rob_idx[i];
            end
        end
        s1_valid_d   = |live;
        b2_valid_d   = s1_valid_q & ~flush;
        b2_info_d    = s1_info_q;
        b2_br_mask_d = s1_br_mask_q & ~b1_resolve_mask_q;
        b2_br_tag_d  = s1_br_tag_q;
        b2_rob_idx_d = s1_rob_idx_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            b1_resolve_mask_q    <= '0;
            b1_mispredict_mask_q <= '0;
            s1_valid_q           <= 1'b0;
            b2_valid_q           <= 1'b0;
        end else begin
            b1_resolve_mask_q    <= b1_resolve_mask_d;
            b1_mispredict_mask_q <= b1_mispredict_mask_d;
            s1_valid_q           <= s1_valid_d;
            b2_valid_q           <= b2_valid_d;
        end
    end

    // Payload is qualified by the valids, so it needs no reset.
    always_ff @(posedge clock) begin
        s1_info_q    <= s1_info_d;
        s1_br_mask_q <= s1_br_mask_d;
        s1_br_tag_q  <= s1_br_tag_d;
        s1_rob_idx_q <= s1_rob_idx_d;
        b2_info_q    <= b2_info_d;
        b2_br_mask_q <= b2_br_mask_d;
        b2_br_tag_q  <= b2_br_tag_d;
        b2_rob_idx_q <= b2_rob_idx_d;
    end

    assign b1_resolve_mask    = b1_resolve_mask_q;
    assign b1_mispredict_mask = b1_mispredict_mask_q;
    assign b2_valid           = b2_valid_q;
    assign b2_mispredict      = b2_info_q.mispredict;
    assign b2_taken           = b2_info_q.taken;
    assign b2_cfi_type        = b2_info_q.cfi_type;
    assign b2_pc_sel          = b2_info_q.pc_sel;
    assign b2_target_offset   = b2_info_q.target_offset;
    assign b2_br_mask         = b2_br_mask_q;
    assign b2_br_tag          = b2_br_tag_q;
    assign b2_rob_idx         = b2_rob_idx_q;
    assign b2_ftq_idx         = b2_info_q.ftq_idx;
    assign b2_pc_lob          = b2_info_q.pc_lob;
    assign b2_ldq_idx         = b2_info_q.ldq_idx;
    assign b2_stq_idx         = b2_info_q.stq_idx;
    assign b2_is_rvc          = b2_info_q.is_rvc;
    assign b2_edge_inst       = b2_info_q.edge_inst;

endmodule

// File: doc/br_update_unit.md
Name: br_update_unit

Overview:
- Collects branch-resolution reports (brinfo) from NUM_BRINFO branch-capable execution units.
- Produces the core-wide branch update that those units and all issue/LSU/ROB structures consume:
  - b1: resolve/mispredict masks, one cycle after the reports.
  - b2: full details of the oldest mispredicting branch, one cycle after b1.
- Sits between the execute stage and the frontend/ROB redirect path.

Parameters:
- NUM_BRINFO, 3, number of brinfo input ports.
- MAX_BR, 20, in-flight branch tags; width of all br_mask signals.
- BR_TAG_W, 5, br_tag width; must satisfy 2^BR_TAG_W >= MAX_BR.
- ROB_IDX_W, 7, ROB index width. The ROB has 2^ROB_IDX_W entries; index arithmetic wraps mod 2^ROB_IDX_W.

Ports:
- clock  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  pipeline flush; invalidates all state next cycle.
- rob_head_idx  in  ROB_IDX_W  oldest ROB entry, used for age compare.
- brinfo_valid  in  NUM_BRINFO  per-port report valid.
- brinfo_mispredict  in  NUM_BRINFO  per-port mispredict.
- brinfo_taken  in  NUM_BRINFO  per-port taken.
- brinfo_cfi_type  in  3*NUM_BRINFO  1 = branch, 3 = jalr.
- brinfo_pc_sel  in  2*NUM_BRINFO  per-port pc_sel.
- brinfo_target_offset  in  21*NUM_BRINFO  per-port target offset.
- brinfo_br_mask  in  MAX_BR*NUM_BRINFO  per-port br_mask.
- brinfo_br_tag  in  BR_TAG_W*NUM_BRINFO  per-port br_tag.
- brinfo_rob_idx  in  ROB_IDX_W*NUM_BRINFO  per-port rob_idx.
- brinfo_ftq_idx  in  6*NUM_BRINFO  per-port ftq_idx.
- brinfo_pc_lob  in  6*NUM_BRINFO  per-port pc_lob.
- brinfo_ldq_idx  in  5*NUM_BRINFO  per-port ldq_idx.
- brinfo_stq_idx  in  5*NUM_BRINFO  per-port stq_idx.
- brinfo_is_rvc  in  NUM_BRINFO  per-port is_rvc.
- brinfo_edge_inst  in  NUM_BRINFO  per-port edge_inst.
- b1_resolve_mask  out  MAX_BR  tags resolved this cycle.
- b1_mispredict_mask  out  MAX_BR  one-hot tag of the oldest mispredict, or 0.
- b2_valid  out  1  b2 payload valid.
- b2_mispredict  out  1  b2 branch mispredicted.
- b2_taken  out  1  b2 branch taken.
- b2_cfi_type  out  3  b2 cfi type.
- b2_pc_sel  out  2  b2 pc_sel.
- b2_target_offset  out  21  b2 target offset.
- b2_br_mask  out  MAX_BR  b2 br_mask.
- b2_br_tag  out  BR_TAG_W  b2 br_tag.
- b2_rob_idx  out  ROB_IDX_W  b2 rob_idx.
- b2_ftq_idx  out  6  b2 ftq_idx.
- b2_pc_lob  out  6  b2 pc_lob.
- b2_ldq_idx  out  5  b2 ldq_idx.
- b2_stq_idx  out  5  b2 stq_idx.
- b2_is_rvc  out  1  b2 is_rvc.
- b2_edge_inst  out  1  b2 edge_inst.

Behaviour:
- Reset (and flush) next edge: b1 masks = 0, b2_valid = 0. b2 payload registers are not reset; they are don't-care while b2_valid = 0.
- Per-port live (cycle T): brinfo_valid[i] & ~flush & (brinfo_br_mask[i] & b1_mispredict_mask) == 0.
  - b1_mispredict_mask is the registered output visible in cycle T, so reports younger than a mispredict on the output are dropped.
- Resolve (T+1): b1_resolve_mask = OR over live ports of (1 << br_tag[i]), with bits at or above MAX_BR discarded.
- Age key: (rob_idx[i] - rob_head_idx) mod 2^ROB_IDX_W; a smaller key is older. Equal keys are resolved by the lower port index winning.
- Oldest select: among live ports with mispredict[i] = 1, pick the oldest.
  - If one exists: at T+1, b1_mispredict_mask = 1 << its br_tag; otherwise 0.
- Stage-1 payload register: captures at T+1 the winning port's fields.
  - If no port mispredicts, it captures the oldest live port instead, with mispredict = 0.
  - Stage-1 valid = any live port.
- b2 (T+2): the stage-1 payload is registered into the b2 outputs.
  - b2_valid = stage-1 valid & ~flush.
  - br_mask is additionally cleared by b1_resolve_mask: b2_br_mask = stage1_br_mask & ~b1_resolve_mask.
- Back-to-back mispredicts in consecutive cycles: both are reported. The second passes only if its br_mask does not contain the first's tag; otherwise it is killed.
- flush has priority over any simultaneous report; reset has priority over flush.
- Pure pipeline: no backpressure, no stall input, fixed latency of 1 (b1) and 2 (b2).

Decomposition:
- Package br_update_pkg:
  - CFI_BR = 3'd1, CFI_JALR = 3'd3.
  - PC_SEL_PLUS4 = 2'd0, PC_SEL_BRJMP = 2'd1, PC_SEL_JALR = 2'd2.
  - brinfo_t struct holding the per-port fields.
  - Default MAX_BR and ROB_IDX_W.
- Sub-module br_oldest_select (combinational):
  - Inputs: request vector, rob_idx vector, rob_head_idx.
  - Output: one-hot grant, using the age-key and tie-break rules above.
  - Instantiated twice: once over mispredicting ports, once over all live ports.

Test Plan:
- Single report: port0 valid, tag 3, mispredict = 0, rob 10, head 0 -> T+1 resolve = 0x00008, mispredict_mask = 0; T+2 b2_valid = 1, b2_mispredict = 0, b2_rob_idx = 10.
- Wrap-around age: head = 120; port0 rob 5 tag 1 mispredict; port1 rob 125 tag 2 mispredict -> mispredict_mask = 0x00004, b2_rob_idx = 125, resolve = 0x00006.
- Kill of younger report: cycle T port0 mispredict tag 4; cycle T+1 port1 valid with br_mask = 0x00010, tag 7 -> port1 ignored, T+2 resolve = 0, mispredict_mask = 0.
- Simultaneous three ports, all mispredict, rob 40/30/50, head 0 -> port1 wins, b2_ftq_idx equals port1's value.
- Flush with report in the same cycle: port0 mispredict tag 0 and flush = 1 -> T+1 masks = 0, T+2 b2_valid = 0.
- Reset mid-operation: mispredict in stage 1 and reset asserted -> next cycle masks = 0 and b2_valid = 0.
